// File: rtl/ex_mem_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_reg
// Brief    : EX/MEM pipeline register with a one-entry skid buffer, flush,
//            bubble-gated controls and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEMTOREG_W = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     read_data2,
    input  logic [REG_ADDR_W-1:0] instruction_mux,
    input  logic                  regwrite,
    input  logic                  memwrite,
    input  logic                  memread,
    input  logic [MEMTOREG_W-1:0] memtoreg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     read_data2_out,
    output logic [REG_ADDR_W-1:0] instruction_mux_out,
    output logic                  regwrite_out,
    output logic                  memwrite_out,
    output logic                  memread_out,
    output logic [MEMTOREG_W-1:0] memtoreg_out,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int PW = 3*DATA_W + REG_ADDR_W + 3 + MEMTOREG_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [PW-1:0]    m_q, m_d, s_q, s_d;
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0] w_in;
    logic          w_accept, w_drain, w_m_rw, w_m_mw, w_m_mr;

    assign w_in     = {pc_in, alu_result, read_data2, instruction_mux,
                       regwrite, memwrite, memread, memtoreg};
    assign w_accept = in_valid & ~s_valid_q;
    assign w_drain  = m_valid_q & out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || w_drain) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = w_accept;
                if (w_accept) s_d = w_in;
            end else begin
                m_valid_d = w_accept;
                if (w_accept) m_d = w_in;
            end
        end else if (w_accept) begin
            // M is stalled: park the incoming instruction in the skid entry.
            s_d       = w_in;
            s_valid_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr)
            cnt_d = '0;
        else if (m_valid_q && !out_ready && cnt_q != C_CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign {pc_out, alu_result_out, read_data2_out, instruction_mux_out,
            w_m_rw, w_m_mw, w_m_mr, memtoreg_out} = m_q;

    // Bubbles must never write memory or the register file.
    assign regwrite_out = w_m_rw & m_valid_q;
    assign memwrite_out = w_m_mw & m_valid_q;
    assign memread_out  = w_m_mr & m_valid_q;
    assign out_valid    = m_valid_q;
    assign in_ready     = ~s_valid_q;
    assign stall_cycles = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage_reg
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int MW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready, stat_clr;
    logic [DW-1:0] pc_in, alu_result, read_data2, pc_out, alu_result_out, read_data2_out;
    logic [RW-1:0] instruction_mux, instruction_mux_out;
    logic          regwrite, memwrite, memread, regwrite_out, memwrite_out, memread_out;
    logic [MW-1:0] memtoreg, memtoreg_out;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.DATA_W(DW), .REG_ADDR_W(RW), .MEMTOREG_W(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .alu_result(alu_result), .read_data2(read_data2),
        .instruction_mux(instruction_mux), .regwrite(regwrite), .memwrite(memwrite),
        .memread(memread), .memtoreg(memtoreg), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .alu_result_out(alu_result_out), .read_data2_out(read_data2_out),
        .instruction_mux_out(instruction_mux_out), .regwrite_out(regwrite_out),
        .memwrite_out(memwrite_out), .memread_out(memread_out), .memtoreg_out(memtoreg_out),
        .stat_clr(stat_clr), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic          iv, ordy, fl, clr, rw, mw;
        logic [DW-1:0] alu;
        logic          eov, eir, erw, emw;
        logic [DW-1:0] ealu;
        logic [CW-1:0] est;
    } vec_t;

    typedef struct {
        logic [DW-1:0] pc, alu, rd2;
        logic [RW-1:0] rd;
        logic          rw, mw, mr;
        logic [MW-1:0] m2r;
    } instr_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic clr,
                         input logic rw, input logic mw, input logic [DW-1:0] alu);
        in_valid        = iv;
        out_ready       = ordy;
        flush           = fl;
        stat_clr        = clr;
        regwrite        = rw;
        memwrite        = mw;
        memread         = 1'b0;
        alu_result      = alu;
        pc_in           = alu ^ 32'h5A5A_0000;
        read_data2      = ~alu;
        instruction_mux = alu[4:0];
        memtoreg        = alu[1:0];
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic rw, input logic mw, input logic [DW-1:0] alu,
                                input logic eov, input logic eir, input logic erw,
                                input logic emw, input logic [DW-1:0] ealu,
                                input logic [CW-1:0] est);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.clr = 1'b0; v.rw = rw; v.mw = mw; v.alu = alu;
        v.eov = eov; v.eir = eir; v.erw = erw; v.emw = emw; v.ealu = ealu; v.est = est;
        return v;
    endfunction

    task automatic chk_basic(input string tag, input logic eov, input logic eir,
                             input logic erw, input logic emw, input logic [CW-1:0] est);
        chk({tag, ".out_valid"}, out_valid, eov);
        chk({tag, ".in_ready"}, in_ready, eir);
        chk({tag, ".regwrite_out"}, regwrite_out, erw);
        chk({tag, ".memwrite_out"}, memwrite_out, emw);
        chk({tag, ".stall_cycles"}, stall_cycles, est);
    endtask

    vec_t   tbl[12];
    instr_t q[$];
    instr_t cur;
    int     st_model;
    logic   pre_ov, pre_ir;

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        repeat (2) step();
        chk_basic("reset", 0, 1, 0, 0, 0);
        chk("reset.fields", {pc_out, alu_result_out, read_data2_out, instruction_mux_out,
                             memtoreg_out, memread_out}, 0);
        reset = 1'b1;

        //          iv ordy fl rw mw alu            eov eir erw emw ealu          est
        tbl[0]  = mk(1, 1, 0, 1, 0, 32'h0000_1234, 1, 1, 1, 0, 32'h0000_1234, 0);
        tbl[1]  = mk(1, 1, 0, 0, 1, 32'h0000_000A, 1, 1, 0, 1, 32'h0000_000A, 0);
        tbl[2]  = mk(1, 0, 0, 1, 0, 32'h0000_000B, 1, 0, 0, 1, 32'h0000_000A, 1);
        tbl[3]  = mk(1, 0, 0, 0, 0, 32'h0000_000C, 1, 0, 0, 1, 32'h0000_000A, 2);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, 1, 32'h0000_000A, 3);
        tbl[5]  = mk(0, 1, 0, 0, 0, 32'h0000_0000, 1, 1, 1, 0, 32'h0000_000B, 3);
        tbl[6]  = mk(0, 1, 0, 0, 0, 32'h0000_0000, 0, 1, 0, 0, 32'h0000_0000, 3);
        tbl[7]  = mk(0, 1, 0, 1, 1, 32'h0000_0077, 0, 1, 0, 0, 32'h0000_0000, 3);
        tbl[8]  = mk(1, 0, 0, 1, 0, 32'h0000_000D, 1, 1, 1, 0, 32'h0000_000D, 3);
        tbl[9]  = mk(1, 0, 0, 0, 0, 32'h0000_000E, 1, 0, 1, 0, 32'h0000_000D, 4);
        tbl[10] = mk(1, 0, 1, 1, 1, 32'h0000_000F, 0, 1, 0, 0, 32'h0000_0000, 5);
        tbl[11] = mk(0, 1, 0, 0, 0, 32'h0000_0000, 0, 1, 0, 0, 32'h0000_0000, 5);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].clr, tbl[i].rw, tbl[i].mw, tbl[i].alu);
            step();
            chk_basic($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eir, tbl[i].erw,
                      tbl[i].emw, tbl[i].est);
            if (tbl[i].eov) chk($sformatf("vec%0d.alu", i), alu_result_out, tbl[i].ealu);
        end

        // Back-to-back streaming of 8 instructions at full rate.
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, 1, 0, 0, 1, 0, 32'h100 + i);
            step();
            if (i < 8) chk($sformatf("stream%0d", i), {out_valid, alu_result_out}, {1'b1, 32'h100 + i});
        end
        chk("stream.end", out_valid, 1'b0);

        // Saturation of the stall counter.
        drive(1, 0, 0, 0, 0, 0, 32'h0000_0066);
        step();
        chk("sat.load", {out_valid, stall_cycles}, {1'b1, 4'd5});
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("sat%0d", i), stall_cycles, (5 + i > 15) ? 4'd15 : 4'(5 + i));
        end
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        step();
        chk("clr.zero", stall_cycles, 4'd0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        chk("clr.resume", stall_cycles, 4'd1);
        drive(1, 0, 1, 1, 0, 1, 32'h0000_0099);
        step();
        chk_basic("flushclr", 0, 1, 0, 0, 0);

        // Asynchronous reset in the middle of a stall with both entries full.
        drive(1, 0, 0, 0, 1, 1, 32'h0000_00A1);
        step();
        drive(1, 0, 0, 0, 1, 1, 32'h0000_00A2);
        step();
        chk_basic("fill", 1, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        #2 reset = 1'b0;
        #1;
        chk_basic("async_rst", 0, 1, 0, 0, 0);
        chk("async_rst.fields", {pc_out, alu_result_out, read_data2_out, instruction_mux_out,
                                 memtoreg_out, memread_out}, 0);
        step();
        reset = 1'b1;

        // Randomized traffic against a queue model of the two-entry buffer.
        st_model = 0;
        for (int n = 0; n < 600; n++) begin
            cur.pc  = $urandom; cur.alu = $urandom; cur.rd2 = $urandom;
            cur.rd  = RW'($urandom); cur.rw = 1'($urandom); cur.mw = 1'($urandom);
            cur.mr  = 1'($urandom); cur.m2r = MW'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) < 3);
            flush = ($urandom_range(0, 29) == 0);
            stat_clr = ($urandom_range(0, 39) == 0);
            pc_in = cur.pc; alu_result = cur.alu; read_data2 = cur.rd2;
            instruction_mux = cur.rd; regwrite = cur.rw; memwrite = cur.mw;
            memread = cur.mr; memtoreg = cur.m2r;

            pre_ov = (q.size() > 0);
            pre_ir = (q.size() < 2);
            if (stat_clr) st_model = 0;
            else if (pre_ov && !out_ready && st_model < 15) st_model++;
            if (flush) q.delete();
            else begin
                if (pre_ov && out_ready) void'(q.pop_front());
                if (in_valid && pre_ir) q.push_back(cur);
            end

            step();
            chk("rnd.valid_ready_cnt", {out_valid, in_ready, stall_cycles},
                {q.size() > 0, q.size() < 2, 4'(st_model)});
            if (q.size() > 0) begin
                chk("rnd.fields", {pc_out, alu_result_out, read_data2_out, instruction_mux_out,
                                   memtoreg_out},
                    {q[0].pc, q[0].alu, q[0].rd2, q[0].rd, q[0].m2r});
                chk("rnd.ctrl", {regwrite_out, memwrite_out, memread_out},
                    {q[0].rw, q[0].mw, q[0].mr});
            end else begin
                chk("rnd.bubble", {regwrite_out, memwrite_out, memread_out}, 3'b000);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline register with valid/ready handshaking, a one-entry skid buffer, synchronous flush, and bubble-safe control gating.
- Sits between the ALU/execute datapath and data memory. Lets a variable-latency memory stage stall execute without losing an instruction.
- Also provides a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 32, width of pc, alu_result, read_data2 fields
- REG_ADDR_W, 5, width of destination register index
- MEMTOREG_W, 2, width of memtoreg select
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  register can accept this cycle
- pc_in  in  DATA_W  PC+4 from execute
- alu_result  in  DATA_W  ALU result
- read_data2  in  DATA_W  store data
- instruction_mux  in  REG_ADDR_W  destination register index
- regwrite, memwrite, memread  in  1 each  control
- memtoreg  in  MEMTOREG_W  writeback select
- out_valid  out  1  memory stage has an instruction
- out_ready  in  1  memory stage consumes this cycle
- pc_out, alu_result_out, read_data2_out  out  DATA_W  registered fields
- instruction_mux_out  out  REG_ADDR_W  registered destination
- regwrite_out, memwrite_out, memread_out  out  1  gated control
- memtoreg_out  out  MEMTOREG_W  registered select
- stat_clr  in  1  synchronous clear of stall counter
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each holds all data/control fields plus a valid bit.
- Reset (reset=0, asynchronous):
  - M, S and all fields clear to 0.
  - out_valid=0, all *_out=0, stall_cycles=0.
  - in_ready=1 (S empty).
- in_ready = !S.valid. It is registered state only and never combinationally depends on out_ready.
- Handshakes:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
  - out_valid = M.valid
- Update priority each clock (first match wins):
  1. flush=1: M.valid<=0, S.valid<=0. Any same-cycle accept is discarded. Data fields may hold stale values.
  2. M empty or drain, and S.valid: M<=S. If accept, S<=input; else S.valid<=0.
  3. M empty or drain, and !S.valid: M<=input if accept, else M.valid<=0.
  4. M held (out_valid & !out_ready) and accept: S<=input.
  5. Otherwise: hold.
- Latency: 1 cycle, in_valid to out_valid, when empty and not stalled. Full throughput of 1/cycle when out_ready=1.
- Order strictly preserved. No instruction is duplicated or dropped, except by flush.
- Control gating:
  - regwrite_out = M.regwrite & M.valid; memwrite_out and memread_out likewise.
  - memtoreg_out and data fields are not gated.
  - A bubble never writes memory or the register file.
- Stall counter:
  - Increments when out_valid & !out_ready; saturates at 2^CNT_W-1.
  - stat_clr takes priority over increment (result 0).
  - Not affected by flush.
- Simultaneous flush and stat_clr: both take effect.
- Reset asserted mid-operation aborts everything immediately. Deassertion is synchronised externally.

Test Plan:
- Reset, then in_valid=1 with alu_result=0x0000_1234, regwrite=1, out_ready=1 -> next cycle out_valid=1, alu_result_out=0x1234, regwrite_out=1. Back-to-back streaming of 8 instructions yields 8 consecutive outputs in order.
- Hold out_ready=0 while sending A then B -> in_ready drops to 0 after B. out shows A for 3 cycles, stall_cycles=3. Raise out_ready -> A, then B, in consecutive cycles; in_ready returns to 1.
- With M and S both full, assert flush with in_valid=1 (memwrite=1) -> next cycle out_valid=0, memwrite_out=0, regwrite_out=0, in_ready=1. The flushed input never appears.
- Drive memwrite=1, in_valid=0 -> memwrite_out stays 0 (gated bubble).
- CNT_W=4, stall for 20 cycles -> stall_cycles saturates at 15. stat_clr pulse during stall -> 0, then resumes counting from 1.
- Pull reset low mid-stall with both entries full -> outputs immediately 0, out_valid=0, in_ready=1, stall_cycles=0.
